// File: rtl/fft_stage_sequencer_if.sv
// fft_stage_sequencer_if: handshake and address bus between the FFT sequencer and its RAM/ROM/butterfly clients.
interface fft_stage_sequencer_if #(
   parameter int LOGN = 3
);
   localparam int SW = $clog2(LOGN);
   logic            start, bfly_ready, issue_valid, wr_en, busy, done;
   logic [LOGN-1:0] addr_a, addr_b, wr_addr_a, wr_addr_b;
   logic [LOGN-2:0] tw_addr;
   logic [SW-1:0]   stage;
   modport master (
      input  start, bfly_ready,
      output issue_valid, addr_a, addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b, stage, busy, done
   );
   modport slave (
      output start, bfly_ready,
      input  issue_valid, addr_a, addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b, stage, busy, done
   );
endinterface

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: stage-by-stage address/handshake sequencer for an in-place radix-2 DIT FFT.
module fft_stage_sequencer #(
   parameter int LOGN = 3,
   parameter int LAT  = 2
) (
   input logic                   clk,
   input logic                   Rst,
   fft_stage_sequencer_if.master bus
);
   localparam int SW = $clog2(LOGN);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t          state;
   logic [LOGN-2:0] k, k_nx;
   logic [SW-1:0]   stage, s_nx;
   logic [LOGN-1:0] kw, span, pos, a_nx, b_nx;
   logic [LOGN-2:0] tw_nx;
   logic [LAT-1:0]  vld;
   logic [LOGN-1:0] pa [LAT];
   logic [LOGN-1:0] pb [LAT];
   logic            acc, drained, load;
   // Operands of the butterfly that will be presented on the next issue cycle.
   always_comb begin
      k_nx    = (state == ISSUE) ? k + 1'b1 : '0;
      s_nx    = (state == DRAIN) ? stage + 1'b1 : (state == ISSUE) ? stage : '0;
      kw      = LOGN'(k_nx);
      span    = LOGN'(1) << s_nx;
      pos     = kw & (span - 1'b1);
      a_nx    = (((kw >> s_nx) << s_nx) << 1) | pos;
      b_nx    = a_nx + span;
      tw_nx   = (LOGN-1)'(pos << (LOGN - 1 - int'(s_nx)));
      acc     = bus.issue_valid & bus.bfly_ready;
      drained = (vld >> 1) == '0;
      load    = (state == IDLE && bus.start) || (state == ISSUE && acc && !(&k)) ||
                (state == DRAIN && drained && stage != SW'(LOGN - 1));
   end
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         state           <= IDLE;
         k               <= '0;
         stage           <= '0;
         bus.issue_valid <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.addr_a      <= '0;
         bus.addr_b      <= '0;
         bus.tw_addr     <= '0;
      end else begin
         bus.done <= 1'b0;
         if (load) begin
            state           <= ISSUE;
            k               <= k_nx;
            stage           <= s_nx;
            bus.issue_valid <= 1'b1;
            bus.busy        <= 1'b1;
            bus.addr_a      <= a_nx;
            bus.addr_b      <= b_nx;
            bus.tw_addr     <= tw_nx;
         end else if (state == ISSUE && acc) begin
            state           <= DRAIN;
            bus.issue_valid <= 1'b0;
         end else if (state == DRAIN && drained) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
         end else if (state == DONE) begin
            state <= IDLE;
            stage <= '0;
         end
      end
   end
   // Write-back pipeline runs freely; entries enter at the top and retire from index 0.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         vld <= '0;
         for (int i = 0; i < LAT; i++) begin
            pa[i] <= '0;
            pb[i] <= '0;
         end
      end else begin
         vld <= (vld >> 1) | (LAT'(acc) << (LAT - 1));
         for (int i = 0; i < LAT - 1; i++) begin
            pa[i] <= pa[i+1];
            pb[i] <= pb[i+1];
         end
         pa[LAT-1] <= bus.addr_a;
         pb[LAT-1] <= bus.addr_b;
      end
   end
   assign bus.stage     = stage;
   assign bus.wr_en     = vld[0];
   assign bus.wr_addr_a = pa[0];
   assign bus.wr_addr_b = pb[0];
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: scoreboard bench for the FFT stage sequencer (LOGN=3/LAT=2 and LOGN=2/LAT=1).
module tb_fft_stage_sequencer;
   typedef struct packed { logic [15:0] c; logic [9:0] a, b, tw; logic [3:0] s; } ev_t;
   logic clk = 1'b0;
   logic Rst = 1'b1;
   int   cnt = 0, t0 = 0, exp_done = 0, act_id = 0, ncmp = 0, nerr = 0;
   bit   act = 1'b0;
   ev_t  iq[$], wq[$], dq[$];
   int   pa3[12]  = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int   pb3[12]  = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int   tw3[12]  = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int   cy3[12]  = '{1, 2, 3, 4, 7, 8, 9, 10, 13, 14, 15, 16};
   int   cy3s[12] = '{1, 2, 3, 4, 7, 11, 12, 13, 16, 17, 18, 19};
   int   pa2[4]   = '{0, 2, 0, 1};
   int   pb2[4]   = '{1, 3, 2, 3};
   int   tw2[4]   = '{0, 0, 0, 1};
   int   cy2[4]   = '{1, 2, 4, 5};

   fft_stage_sequencer_if #(.LOGN(3)) s3 ();
   fft_stage_sequencer_if #(.LOGN(2)) s2 ();
   fft_stage_sequencer #(.LOGN(3), .LAT(2)) u3 (.clk(clk), .Rst(Rst), .bus(s3.master));
   fft_stage_sequencer #(.LOGN(2), .LAT(1)) u2 (.clk(clk), .Rst(Rst), .bus(s2.master));

   always #5 clk = ~clk;
   always @(posedge clk) cnt <= cnt + 1;

   task automatic chk(string n, int g, int e);
      ncmp++;
      if (g !== e) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", n, g, e);
      end
   endtask

   task automatic chk_ev(string n, ev_t g, ev_t e);
      ncmp++;
      if (g !== e) begin
         nerr++;
         $display("FAIL %s: got cyc=%0d a=%0d b=%0d tw=%0d st=%0d expected cyc=%0d a=%0d b=%0d tw=%0d st=%0d",
                  n, g.c, g.a, g.b, g.tw, g.s, e.c, e.a, e.b, e.tw, e.s);
      end
   endtask

   task automatic observe(int id, logic iv, logic rdy, logic we, logic bsy, logic dn, ev_t is, ev_t wr);
      int  rel = cnt - t0;
      ev_t e, g;
      is.c = 16'(rel);
      wr.c = 16'(rel);
      if (act && id == act_id) chk("busy", int'(bsy), int'(rel >= 1 && rel < exp_done));
      if (iv) begin
         if (iq.size() == 0) chk("unexpected_issue", 1, 0);
         else if (!rdy) begin
            e   = iq[0];
            e.c = is.c;
            chk_ev("stall_hold", is, e);
         end else chk_ev("issue", is, iq.pop_front());
      end
      if (we) begin
         if (wq.size() == 0) chk("unexpected_write", 1, 0);
         else chk_ev("write", wr, wq.pop_front());
      end
      if (dn) begin
         g = '{c: 16'(rel), a: '0, b: '0, tw: '0, s: is.s};
         if (dq.size() == 0) chk("unexpected_done", 1, 0);
         else chk_ev("done", g, dq.pop_front());
      end
   endtask

   always @(negedge clk) if (!Rst)
      observe(0, s3.issue_valid, s3.bfly_ready, s3.wr_en, s3.busy, s3.done,
              '{c: 0, a: 10'(s3.addr_a), b: 10'(s3.addr_b), tw: 10'(s3.tw_addr), s: 4'(s3.stage)},
              '{c: 0, a: 10'(s3.wr_addr_a), b: 10'(s3.wr_addr_b), tw: '0, s: '0});
   always @(negedge clk) if (!Rst)
      observe(1, s2.issue_valid, s2.bfly_ready, s2.wr_en, s2.busy, s2.done,
              '{c: 0, a: 10'(s2.addr_a), b: 10'(s2.addr_b), tw: 10'(s2.tw_addr), s: 4'(s2.stage)},
              '{c: 0, a: 10'(s2.wr_addr_a), b: 10'(s2.wr_addr_b), tw: '0, s: '0});

   task automatic plan(int id, bit stall, int dcyc);
      int n = (id == 0) ? 12 : 4;
      for (int i = 0; i < n; i++) begin
         int c  = (id == 1) ? cy2[i] : stall ? cy3s[i] : cy3[i];
         int a  = (id == 1) ? pa2[i] : pa3[i];
         int b  = (id == 1) ? pb2[i] : pb3[i];
         int tw = (id == 1) ? tw2[i] : tw3[i];
         int st = (id == 1) ? i / 2 : i / 4;
         int lt = (id == 1) ? 1 : 2;
         iq.push_back('{c: 16'(c), a: 10'(a), b: 10'(b), tw: 10'(tw), s: 4'(st)});
         wq.push_back('{c: 16'(c + lt), a: 10'(a), b: 10'(b), tw: '0, s: '0});
      end
      dq.push_back('{c: 16'(dcyc), a: '0, b: '0, tw: '0, s: 4'((id == 1) ? 1 : 2)});
      exp_done = dcyc;
   endtask

   task automatic go(int id);
      @(posedge clk); #1;
      t0     = cnt;
      act_id = id;
      act    = 1'b1;
      if (id == 0) s3.start = 1'b1;
      else s2.start = 1'b1;
      @(posedge clk); #1;
      s3.start = 1'b0;
      s2.start = 1'b0;
   endtask

   task automatic at(int c);
      while (cnt - t0 < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic finish_pass();
      int n = 0;
      while (dq.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_seen", dq.size(), 0);
      act = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("leftover", iq.size() + wq.size(), 0);
      chk("idle_busy", int'(s3.busy | s2.busy | s3.issue_valid | s2.issue_valid), 0);
      chk("idle_stage", int'(s3.stage) + int'(s2.stage), 0);
   endtask

   task automatic chk_zero3(string n);
      chk({n, "_issue"}, int'({s3.issue_valid, s3.addr_a, s3.addr_b, s3.tw_addr}), 0);
      chk({n, "_write"}, int'({s3.wr_en, s3.wr_addr_a, s3.wr_addr_b}), 0);
      chk({n, "_status"}, int'({s3.stage, s3.busy, s3.done}), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      s3.start = 1'b0; s3.bfly_ready = 1'b1;
      s2.start = 1'b0; s2.bfly_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero3("reset");
      chk("reset_u2", int'({s2.issue_valid, s2.addr_a, s2.addr_b, s2.tw_addr, s2.wr_en, s2.busy, s2.done, s2.stage}), 0);
      Rst = 1'b0;
      plan(0, 1'b0, 19);
      go(0);
      finish_pass();
      plan(0, 1'b0, 19);
      go(0);
      at(2);
      s3.start = 1'b1;
      @(posedge clk); #1;
      s3.start = 1'b0;
      at(5);
      s3.start = 1'b1;
      @(posedge clk); #1;
      s3.start = 1'b0;
      finish_pass();
      plan(0, 1'b1, 22);
      go(0);
      at(8);
      s3.bfly_ready = 1'b0;
      at(11);
      s3.bfly_ready = 1'b1;
      finish_pass();
      plan(1, 1'b0, 7);
      go(1);
      finish_pass();
      plan(0, 1'b0, 19);
      go(0);
      at(9);
      #2;
      Rst = 1'b1;
      #1;
      chk_zero3("midpass_reset");
      iq.delete();
      wq.delete();
      dq.delete();
      act = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      Rst = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         chk("post_reset_wr_en", int'(s3.wr_en), 0);
         chk("post_reset_active", int'(s3.issue_valid | s3.busy | s3.done), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
